uart_rx_oversample: RTL
=======================

Name: uart_rx_oversample

Overview:
- Serial receive front end feeding the UART RX FIFO.
- Converts the asynchronous `rx` pin into 8-bit bytes plus a one-cycle write strobe, which connects directly to the FIFO `wrreq`.
- Uses 16x oversampling with a majority-vote bit decision and start-bit glitch rejection.
- Reports framing errors so the bus-side wrapper can expose line status.

Parameters:
- clkfreq, 50000000, system clock frequency in Hz.
- baud, 9600, line rate in bits per second.
- DIV, (clkfreq + baud*8)/(baud*16), clocks per oversample tick (rounded); 326 at the defaults.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous active-high reset.
- serial_in  input  1  asynchronous RX line; idle high.
- data  output  8  last received byte, LSB-first assembled; held until the next byte completes.
- ready  output  1  one-clock strobe when `data` is valid; connects to FIFO `wrreq`.
- frame_err  output  1  one-clock strobe when the stop bit is sampled low.
- parity_err  output  1  one-clock strobe on parity mismatch; constant 0 without the optional feature.
- busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset (async): state=IDLE; data=8'h00; ready=0; frame_err=0; parity_err=0; busy=0.
  - Tick counter clears to 0.
  - Both synchronizer flops set to 1, so reset does not cause a false start.
- Input sync: 2-flop synchronizer on serial_in. All logic below uses the synchronized value `rxs`.
- Tick generator:
  - Counter runs 0..DIV-1 and emits `tick` on wrap.
  - Counter is cleared on the IDLE->START transition, so sampling is phase-aligned to the detected edge.
- Sample counter: 4-bit, 0..15, advances on `tick`.
  - Bit value = majority of rxs sampled at sample counts 7, 8 and 9.
  - Bit decision is taken at sample 15 (end of bit).
- State machine:
  - IDLE: rxs falling to 0 -> START; sample counter cleared, busy=1.
  - START:
    - At sample 8, rxs=1 -> IDLE (glitch rejected, no strobe).
    - At end of bit, a majority-0 result -> DATA, with bit index=0.
  - DATA:
    - Shift the majority bit into a shift register at bit[index].
    - After index 7 -> PARITY (feature on) or STOP.
  - PARITY (feature only): decide the parity bit -> STOP.
  - STOP: the stop bit is decided at sample 9, not sample 15. This lets back-to-back frames re-sync within half a bit. Then:
    - data <= shift register.
    - ready pulses for exactly 1 clock.
    - If majority = 0, frame_err pulses in the same cycle. Data is still delivered.
    - Return to IDLE.
- Line held low (break): after a frame_err, IDLE does not re-trigger until rxs has been seen high for at least 1 clock. Every new start requires a real falling edge.
- ready, frame_err and parity_err never assert outside STOP completion.
- data changes only in the cycle ready asserts.
- No backpressure: the downstream FIFO dropping the byte when full is acceptable, and this block does not stall.
- Latency: ready asserts about 9.6 bit-times after the start-edge crossing, plus 2 sync clocks.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is start + 8 data + 1 parity + stop. Parity is even: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, parity_err pulses with ready. The byte is still delivered.
  - Frame is 11 bit-times long.
- Undefined:
  - No PARITY state.
  - parity_err is tied to 0.
  - Frame is 10 bit-times long.

Test Plan:
- Reset mid-frame: assert rst_i during DATA bit 3 -> outputs at reset values immediately. A following clean 8'hA5 frame is received with ready=1 for 1 clock and data=8'hA5.
- Byte 8'h55 at 9600 baud (defaults) -> one ready pulse ~10 bit-times after start; data=8'h55, frame_err=0, busy low afterward.
- Glitch: drive serial_in low for 3 ticks then high -> returns to IDLE; no ready, frame_err=0. A following 8'h3C frame is received correctly.
- Framing error: send 8'hFF with stop bit low, then hold the line low for 2 bit-times -> ready and frame_err both pulse, with data=8'hFF. No further start occurs until the line returns high.
- Back-to-back frames 8'h00, 8'hFF, 8'h81 with no idle gap, and baud skewed +2% -> three ready pulses with the correct data and no errors.
- (UART_RX_PARITY_EN) Send 8'h07 with parity bit 1, then 8'h07 with parity bit 0 -> first frame parity_err=0; second frame parity_err=1 with ready=1 and data=8'h07.

Source files
------------

// File: rtl/uart_rx_oversample_if.sv
// Receive-side bus from the UART RX front end to the RX FIFO / line-status wrapper.
// The receiver drives it through the master modport; the FIFO side reads it through slave.
interface uart_rx_oversample_if;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (output data, ready, frame_err, parity_err, busy);
    modport slave  (input  data, ready, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_oversample.sv
// 16x-oversampled UART receiver with majority-vote bits and start-glitch rejection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_oversample #(
    parameter int clkfreq = 50000000,
    parameter int baud    = 9600
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  serial_in,
    uart_rx_oversample_if.master  bus
);
    localparam int DIV = (clkfreq + baud*8) / (baud*16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [3:0]    smp;
    logic [2:0]    v;
    logic [7:0]    shreg;
    logic [2:0]    idx;
    logic          armed;
`ifdef UART_RX_PARITY_EN
    logic          perr;
`endif

    logic rxs, tick, vote_end, vote_stop;
    assign rxs       = sync[1];
    assign tick      = (cnt == CW'(DIV-1));
    assign vote_end  = maj3(v[0], v[1], v[2]);
    // Stop bit is voted at sample 9 so the next start edge is never missed.
    assign vote_stop = maj3(v[0], v[1], rxs);

`ifndef UART_RX_PARITY_EN
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            sync          <= 2'b11;
            cnt           <= '0;
            smp           <= '0;
            v             <= '0;
            shreg         <= '0;
            idx           <= '0;
            armed         <= 1'b0;
            bus.data      <= 8'h00;
            bus.ready     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr           <= 1'b0;
            bus.parity_err <= 1'b0;
`endif
        end else begin
            sync          <= {sync[0], serial_in};
            bus.ready     <= 1'b0;
            bus.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                smp <= smp + 4'd1;
                if (smp == 4'd7) v[0] <= rxs;
                if (smp == 4'd8) v[1] <= rxs;
                if (smp == 4'd9) v[2] <= rxs;
            end

            case (state)
                IDLE: begin
                    // armed demands a high level first, so a held-low break cannot retrigger
                    if (rxs) armed <= 1'b1;
                    else if (armed) begin
                        state    <= START;
                        cnt      <= '0;
                        smp      <= '0;
                        armed    <= 1'b0;
                        bus.busy <= 1'b1;
                    end
                end
                START: if (tick) begin
                    if (smp == 4'd8 && rxs) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (smp == 4'd15) begin
                        if (!vote_end) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                DATA: if (tick && smp == 4'd15) begin
                    shreg[idx] <= vote_end;
                    idx        <= idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx == 3'd7) state <= PARITY;
`else
                    if (idx == 3'd7) state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick && smp == 4'd15) begin
                    perr  <= (^shreg) ^ vote_end;
                    state <= STOP;
                end
`endif
                STOP: if (tick && smp == 4'd9) begin
                    bus.data      <= shreg;
                    bus.ready     <= 1'b1;
                    bus.frame_err <= ~vote_stop;
`ifdef UART_RX_PARITY_EN
                    bus.parity_err <= perr;
`endif
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
